// File: rtl/condicionador_botoes_if.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_botoes_if
// Description : Board-side bundle between the raw pushbuttons and the
//               conditioned button outputs (pulses, mute level, pressed state).
// Revision    : 1.0 - initial release
// ============================================================================
interface condicionador_botoes_if;
  logic [3:0] btn_n;
  logic       play_loc;
  logic       sel_loc;
  logic       stop_loc;
  logic       mute_loc;
  logic [3:0] btn_estado;

  // Board / stimulus side: drives the raw pins, observes conditioned outputs
  modport master (
    output btn_n,
    input  play_loc,
    input  sel_loc,
    input  stop_loc,
    input  mute_loc,
    input  btn_estado
  );

  // Conditioner side: receives the raw pins, produces conditioned outputs
  modport slave (
    input  btn_n,
    output play_loc,
    output sel_loc,
    output stop_loc,
    output mute_loc,
    output btn_estado
  );
endinterface
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_botoes
// Description : Four-channel pushbutton conditioner. Each active-low pin is
//               synchronized, then debounced by its own FSM that requires
//               DEB_CYCLES+1 consecutive agreeing samples before accepting a
//               press or release. Play/sel/stop emit a one-cycle registered
//               pulse per accepted press; mute is exported as a level.
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_botoes #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  wire logic             clk_placa,
  input  wire logic             rst,
  condicionador_botoes_if.slave bus
);

  localparam logic [15:0] c_limite = DEB_CYCLES - 16'd1;

  localparam logic [1:0] c_solto       = 2'd0;
  localparam logic [1:0] c_conf_aperto = 2'd1;
  localparam logic [1:0] c_apertado    = 2'd2;
  localparam logic [1:0] c_conf_solto  = 2'd3;

  logic [3:0] w_pressionado;
  logic [2:0] w_pulso;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_canal
      logic [1:0]  r_sinc;
      logic        w_pino;
      logic [1:0]  r_estado;
      logic [1:0]  w_prox_estado;
      logic [15:0] r_cnt;
      logic [15:0] w_prox_cnt;
      logic        w_apertado;

      // Oldest synchronizer stage is the only copy of the pin the FSM sees
      assign w_pino = r_sinc[1];

      // Two-flop synchronizer; idles at the released level
      always_ff @(posedge clk_placa) begin
        if (rst) begin
          r_sinc <= 2'b11;
        end else begin
          r_sinc <= {r_sinc[0], bus.btn_n[i]};
        end
      end

      // State and confirmation counter registers
      always_ff @(posedge clk_placa) begin
        if (rst) begin
          r_estado <= c_solto;
          r_cnt    <= 16'd0;
        end else begin
          r_estado <= w_prox_estado;
          r_cnt    <= w_prox_cnt;
        end
      end

      // Next-state logic: a change is accepted only after the counter reaches
      // its limit with the pin still at the new level; any disagreement
      // falls back to the previous stable state and restarts from zero.
      always_comb begin
        w_prox_estado = r_estado;
        w_prox_cnt    = r_cnt;
        case (r_estado)
          c_solto: begin
            if (!w_pino) begin
              w_prox_estado = c_conf_aperto;
              w_prox_cnt    = 16'd0;
            end
          end
          c_conf_aperto: begin
            if (w_pino) begin
              w_prox_estado = c_solto;
              w_prox_cnt    = 16'd0;
            end else if (r_cnt == c_limite) begin
              w_prox_estado = c_apertado;
              w_prox_cnt    = 16'd0;
            end else begin
              w_prox_cnt    = r_cnt + 16'd1;
            end
          end
          c_apertado: begin
            if (w_pino) begin
              w_prox_estado = c_conf_solto;
              w_prox_cnt    = 16'd0;
            end
          end
          c_conf_solto: begin
            if (!w_pino) begin
              w_prox_estado = c_apertado;
              w_prox_cnt    = 16'd0;
            end else if (r_cnt == c_limite) begin
              w_prox_estado = c_solto;
              w_prox_cnt    = 16'd0;
            end else begin
              w_prox_cnt    = r_cnt + 16'd1;
            end
          end
          default: begin
            w_prox_estado = c_solto;
            w_prox_cnt    = 16'd0;
          end
        endcase
      end

      // Output logic: release is still unconfirmed in CONF_SOLTO, so the
      // button keeps reading as pressed there.
      always_comb begin
        w_apertado = (r_estado == c_apertado) || (r_estado == c_conf_solto);
      end

      assign w_pressionado[i] = w_apertado;

      // Only play/sel/stop are edge-type controls; mute gets no pulse
      if (i < 3) begin : g_pulso
        logic r_pulso;

        // Registered pulse on the exact cycle a press is confirmed
        always_ff @(posedge clk_placa) begin
          if (rst) begin
            r_pulso <= 1'b0;
          end else begin
            r_pulso <= (r_estado == c_conf_aperto) && !w_pino && (r_cnt == c_limite);
          end
        end

        assign w_pulso[i] = r_pulso;
      end
    end
  endgenerate

  assign bus.play_loc   = w_pulso[0];
  assign bus.sel_loc    = w_pulso[1];
  assign bus.stop_loc   = w_pulso[2];
  assign bus.mute_loc   = ~w_pressionado[3];
  assign bus.btn_estado = w_pressionado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module      : tb_condicionador_botoes
// Description : Scoreboard bench for condicionador_botoes with DEB_CYCLES=4.
//               A run-length reference model predicts accepted presses and
//               the debounced state; a negedge monitor compares the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

  localparam int c_deb = 4;

  typedef struct {
    int canal;
    int ciclo;
  } evento_t;

  logic clk_placa = 1'b0;
  logic rst       = 1'b1;

  condicionador_botoes_if bus ();

  condicionador_botoes #(
    .DEB_CYCLES (16'(c_deb))
  ) dut (
    .clk_placa (clk_placa),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_placa = ~clk_placa;

  int         checks = 0;
  int         errors = 0;
  int         ciclo  = 0;
  bit         ativo  = 1'b0;
  evento_t    fila[$];
  logic [3:0] m_s1  = 4'hF;
  logic [3:0] m_s2  = 4'hF;
  logic [3:0] m_acc = 4'h0;
  int         m_run[4];
  int         n_pulsos[3];
  int         ult_pulso[3];
  bit         viu_sel;

  task automatic verifica(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    checks++;
    if (obtido !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, obtido, esperado, ciclo);
    end
  endtask

  // Reference model: a change is accepted once the synchronized pin has
  // disagreed with the accepted state for c_deb+1 consecutive samples.
  always @(posedge clk_placa) begin
    ciclo++;
    if (rst) begin
      m_s1  = 4'hF;
      m_s2  = 4'hF;
      m_acc = 4'h0;
      for (int ch = 0; ch < 4; ch++) m_run[ch] = 0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!m_s2[ch] == m_acc[ch]) begin
          m_run[ch] = 0;
        end else begin
          m_run[ch]++;
          if (m_run[ch] == c_deb + 1) begin
            m_acc[ch] = !m_s2[ch];
            m_run[ch] = 0;
            if (m_acc[ch] && ch < 3) fila.push_back('{canal: ch, ciclo: ciclo});
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn_n;
    end
  end

  // Monitor: match every pulse to a predicted event, flag missed ones
  always @(negedge clk_placa) begin
    logic [2:0] p;
    bit achou;
    if (ativo) begin
      p = {bus.stop_loc, bus.sel_loc, bus.play_loc};
      if (bus.btn_estado[1]) viu_sel = 1'b1;
      for (int ch = 0; ch < 3; ch++) begin
        if (p[ch]) begin
          n_pulsos[ch]++;
          ult_pulso[ch] = ciclo;
          achou = 1'b0;
          for (int k = 0; k < fila.size(); k++) begin
            if (fila[k].canal == ch && fila[k].ciclo == ciclo) begin
              fila.delete(k);
              achou = 1'b1;
              break;
            end
          end
          checks++;
          if (!achou) begin
            errors++;
            $display("FAIL pulse_unexpected: channel %0d pulsed at cycle %0d, no press predicted", ch, ciclo);
          end
        end
      end
      while (fila.size() > 0 && fila[0].ciclo <= ciclo) begin
        checks++;
        errors++;
        $display("FAIL pulse_missing: channel %0d got no pulse, expected at cycle %0d", fila[0].canal, fila[0].ciclo);
        void'(fila.pop_front());
      end
      verifica("btn_estado", 32'(bus.btn_estado), 32'(m_acc));
      verifica("mute_loc", 32'(bus.mute_loc), 32'(!m_acc[3]));
    end
  end

  task automatic espera(input int n);
    repeat (n) @(posedge clk_placa);
    #2;
  endtask

  task automatic zera_contagem();
    for (int ch = 0; ch < 3; ch++) begin
      n_pulsos[ch]  = 0;
      ult_pulso[ch] = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget at cycle %0d", ciclo);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int t1;
    logic [31:0] r;
    bus.btn_n = 4'hF;
    rst       = 1'b1;
    zera_contagem();
    espera(3);
    ativo = 1'b1;
    verifica("reset_play", 32'(bus.play_loc), 32'd0);
    verifica("reset_sel", 32'(bus.sel_loc), 32'd0);
    verifica("reset_stop", 32'(bus.stop_loc), 32'd0);
    verifica("reset_mute", 32'(bus.mute_loc), 32'd1);
    verifica("reset_estado", 32'(bus.btn_estado), 32'd0);
    rst = 1'b0;
    espera(2);

    // Clean play press
    zera_contagem();
    t0 = ciclo;
    bus.btn_n = 4'b1110;
    espera(20);
    verifica("play_latency", 32'(ult_pulso[0]), 32'(t0 + 7));
    verifica("play_count", 32'(n_pulsos[0]), 32'd1);
    verifica("play_estado_held", 32'(bus.btn_estado[0]), 32'd1);
    bus.btn_n = 4'hF;
    espera(10);

    // Bounce only
    zera_contagem();
    viu_sel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.btn_n = 4'b1101; espera(3);
      bus.btn_n = 4'hF;    espera(1);
    end
    espera(10);
    verifica("bounce_sel_count", 32'(n_pulsos[1]), 32'd0);
    verifica("bounce_sel_estado", 32'(viu_sel), 32'd0);

    // Bounce then stable
    for (int k = 0; k < 5; k++) begin
      bus.btn_n = 4'b1101; espera(3);
      bus.btn_n = 4'hF;    espera(1);
    end
    t0 = ciclo;
    bus.btn_n = 4'b1101;
    espera(10);
    bus.btn_n = 4'hF;
    espera(10);
    verifica("bounce_stable_latency", 32'(ult_pulso[1]), 32'(t0 + 7));
    verifica("bounce_stable_count", 32'(n_pulsos[1]), 32'd1);

    // Simultaneous play + stop
    zera_contagem();
    t0 = ciclo;
    bus.btn_n = 4'b1010;
    espera(12);
    bus.btn_n = 4'hF;
    espera(10);
    verifica("simul_play_at", 32'(ult_pulso[0]), 32'(t0 + 7));
    verifica("simul_stop_at", 32'(ult_pulso[2]), 32'(t0 + 7));
    verifica("simul_play_count", 32'(n_pulsos[0]), 32'd1);
    verifica("simul_stop_count", 32'(n_pulsos[2]), 32'd1);

    // Mute level
    zera_contagem();
    t0 = ciclo;
    bus.btn_n = 4'b0111;
    espera(6);
    verifica("mute_before", 32'(bus.mute_loc), 32'd1);
    espera(1);
    verifica("mute_held", 32'(bus.mute_loc), 32'd0);
    espera(3);
    t1 = ciclo;
    bus.btn_n = 4'hF;
    espera(6);
    verifica("mute_release_before", 32'(bus.mute_loc), 32'd0);
    espera(1);
    verifica("mute_released", 32'(bus.mute_loc), 32'd1);
    verifica("mute_no_pulse", 32'(n_pulsos[0] + n_pulsos[1] + n_pulsos[2]), 32'd0);
    verifica("mute_release_cycle", 32'(ciclo), 32'(t1 + 7));
    espera(5);

    // Reset in the middle of a stop confirmation
    zera_contagem();
    t0 = ciclo;
    bus.btn_n = 4'b1011;
    espera(5);
    rst = 1'b1;
    espera(1);
    verifica("midrst_stop", 32'(bus.stop_loc), 32'd0);
    verifica("midrst_estado", 32'(bus.btn_estado), 32'd0);
    verifica("midrst_mute", 32'(bus.mute_loc), 32'd1);
    rst = 1'b0;
    espera(12);
    verifica("midrst_stop_at", 32'(ult_pulso[2]), 32'(t0 + 13));
    verifica("midrst_stop_count", 32'(n_pulsos[2]), 32'd1);
    bus.btn_n = 4'hF;
    espera(10);

    // Randomized pin activity with occasional resets
    for (int k = 0; k < 250; k++) begin
      r = $urandom;
      bus.btn_n = r[3:0];
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        espera(1);
        rst = 1'b0;
      end
      espera($urandom_range(1, 9));
    end

    bus.btn_n = 4'hF;
    espera(15);
    verifica("queue_drained", 32'(fila.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter DEB_CYCLES, default 16'd50000 (1 ms at 50 MHz), is the number of consecutive stable cycles required to accept a button change; the legal range is 1..65535.
REQ-002 clk_placa  input  1  is the single board clock, and all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  is the reset, which SHALL be synchronous and active-high.
REQ-004 btn_n  input  4  carries the raw active-low board pushbuttons: [0] play, [1] sel, [2] stop, [3] mute.
REQ-005 play_loc  output  1  SHALL be a one-cycle pulse on each accepted play press.
REQ-006 sel_loc  output  1  SHALL be a one-cycle pulse on each accepted sel press.
REQ-007 stop_loc  output  1  SHALL be a one-cycle pulse on each accepted stop press.
REQ-008 mute_loc  output  1  SHALL be the debounced mute level: 1 = released, 0 = held.
REQ-009 btn_estado  output  4  SHALL give the debounced active-high pressed state of each channel, in the same bit order as btn_n.

Function
REQ-010 Each btn_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL have an independent 4-state FSM (SOLTO, CONF_APERTO, APERTADO, CONF_SOLTO) and an independent 16-bit counter cnt.
REQ-012 SOLTO: when the synced pin is 0, the FSM SHALL go to CONF_APERTO with cnt=0; otherwise it SHALL stay.
REQ-013 CONF_APERTO: when the synced pin is 1, the FSM SHALL return to SOLTO with cnt=0 and no pulse.
REQ-014 CONF_APERTO: when the synced pin is 0 and cnt==DEB_CYCLES-1, the FSM SHALL go to APERTADO with cnt=0 and raise that channel's pulse for the next cycle.
REQ-015 CONF_APERTO: when the synced pin is 0 and cnt!=DEB_CYCLES-1, the FSM SHALL increment cnt.
REQ-016 APERTADO: when the synced pin is 1, the FSM SHALL go to CONF_SOLTO with cnt=0; otherwise it SHALL stay, with no further pulses (no auto-repeat).
REQ-017 CONF_SOLTO SHALL mirror CONF_APERTO with polarity reversed: a 0 on the synced pin returns to APERTADO, and cnt==DEB_CYCLES-1 with a 1 on the synced pin goes to SOLTO; no pulse SHALL be generated on release.
REQ-018 btn_estado[i] SHALL be 1 in APERTADO and CONF_SOLTO, and 0 in SOLTO and CONF_APERTO.
REQ-019 Latency: if the pin is first sampled low at edge E0 and held, the FSM SHALL enter APERTADO at edge E0+DEB_CYCLES+2, and the pulse SHALL be high for exactly the one clock period following that edge.
REQ-020 Pulse outputs SHALL be registered, and each SHALL be high for no more than one cycle per accepted press.
REQ-021 Any bounce shorter than DEB_CYCLES stable cycles SHALL produce no pulse and no btn_estado change.
REQ-022 Simultaneous presses on several channels SHALL be handled independently; pulses may coincide, and there is no priority or masking.
REQ-023 cnt SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-024 mute_loc SHALL equal ~btn_estado[3]; the mute channel SHALL NOT produce a pulse.

Reset
REQ-025 While rst=1 at a clock edge, synchronizer flops SHALL load 1, all FSMs SHALL load SOLTO, and all cnt SHALL load 0.
REQ-026 While rst=1 at a clock edge, play_loc, sel_loc and stop_loc SHALL load 0, btn_estado SHALL load 4'b0000, and mute_loc SHALL load 1.
REQ-027 Reset asserted mid-confirmation SHALL abort it with no pulse; a button still held at deassertion SHALL be re-qualified from SOLTO and then pulse once.
REQ-028 rst SHALL take priority over all FSM activity in the same cycle.

Verification (DEB_CYCLES=4)
REQ-029 Clean press: btn_n[0] 1->0, held 20 cycles -> play_loc high exactly 1 cycle, 6 edges after the first low sample; btn_estado[0]=1 until release is confirmed.
REQ-030 Bounce: btn_n[1] toggles low 3 cycles, high 1 cycle, repeated 5 times, then high -> sel_loc stays 0 and btn_estado[1] stays 0 throughout.
REQ-031 Bounce then stable: same bounce as REQ-030, then held low 10 cycles -> exactly one sel_loc pulse, 6 edges after the final low begins.
REQ-032 Simultaneous: btn_n[0] and btn_n[2] fall on the same edge -> play_loc and stop_loc pulse in the same cycle, once each.
REQ-033 Mute level: btn_n[3] held low 10 cycles -> mute_loc goes 0 after 6 edges, returns to 1 at 6 edges after release, and no pulse output toggles.
REQ-034 Reset mid-operation: rst=1 for 1 cycle at cnt=2 with stop held -> no pulse, all outputs at reset values, then one stop_loc pulse 6 edges after rst deasserts.
